// File: rtl/decode_queue.sv
// RV32I decode stage: decodes each accepted word and buffers the record in a DEPTH-entry FIFO.
// Optional feature macro: DECODE_CSR_EN (CSR instructions and mret/sret/wfi decode).
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [47:0]            out_flags,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [31:0]            out_imm,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [47:0]     flags;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            illegal;
  } entry_t;

  logic [47:0] dec_flags;
  logic [31:0] dec_imm;
  logic        dec_ill;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec_flags = '0;
    dec_imm   = '0;
    dec_ill   = 1'b0;
    if (in_instr == 32'h0) begin
      dec_ill = 1'b0;
    end else if (in_instr[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (in_instr[6:2])
        5'b01101: begin dec_flags[28] = 1'b1; dec_imm = imm_u; end
        5'b00101: begin dec_flags[8]  = 1'b1; dec_imm = imm_u; end
        5'b11011: begin dec_flags[7]  = 1'b1; dec_imm = imm_j; end
        5'b11001: begin
          dec_flags[6] = 1'b1;
          dec_imm      = imm_i;
          dec_ill      = (in_instr[14:12] != 3'b000);
        end
        5'b11000: begin
          dec_imm = imm_b;
          case (in_instr[14:12])
            3'b000:  dec_flags[0] = 1'b1;
            3'b001:  dec_flags[5] = 1'b1;
            3'b100:  dec_flags[3] = 1'b1;
            3'b101:  dec_flags[1] = 1'b1;
            3'b110:  dec_flags[4] = 1'b1;
            3'b111:  dec_flags[2] = 1'b1;
            default: dec_ill = 1'b1;
          endcase
        end
        5'b00000: begin
          dec_imm = imm_i;
          case (in_instr[14:12])
            3'b000:  dec_flags[29] = 1'b1;
            3'b001:  dec_flags[31] = 1'b1;
            3'b010:  dec_flags[33] = 1'b1;
            3'b100:  dec_flags[30] = 1'b1;
            3'b101:  dec_flags[32] = 1'b1;
            default: dec_ill = 1'b1;
          endcase
        end
        5'b01000: begin
          dec_imm = imm_s;
          case (in_instr[14:12])
            3'b000:  dec_flags[34] = 1'b1;
            3'b001:  dec_flags[35] = 1'b1;
            3'b010:  dec_flags[36] = 1'b1;
            default: dec_ill = 1'b1;
          endcase
        end
        5'b00100: begin
          dec_imm = imm_i;
          case (in_instr[14:12])
            3'b000: dec_flags[9]  = 1'b1;
            3'b010: dec_flags[13] = 1'b1;
            3'b011: dec_flags[14] = 1'b1;
            3'b100: dec_flags[17] = 1'b1;
            3'b110: dec_flags[11] = 1'b1;
            3'b111: dec_flags[10] = 1'b1;
            3'b001: begin dec_flags[12] = 1'b1; dec_ill = in_instr[25]; end
            default: begin
              if (in_instr[30]) dec_flags[15] = 1'b1;
              else              dec_flags[16] = 1'b1;
              dec_ill = in_instr[25];
            end
          endcase
        end
        5'b01100: begin
          case (in_instr[14:12])
            3'b000:  if (in_instr[30]) dec_flags[26] = 1'b1; else dec_flags[18] = 1'b1;
            3'b001:  dec_flags[21] = 1'b1;
            3'b010:  dec_flags[22] = 1'b1;
            3'b011:  dec_flags[23] = 1'b1;
            3'b100:  dec_flags[27] = 1'b1;
            3'b101:  if (in_instr[30]) dec_flags[24] = 1'b1; else dec_flags[25] = 1'b1;
            3'b110:  dec_flags[20] = 1'b1;
            default: dec_flags[19] = 1'b1;
          endcase
        end
        5'b11100: begin
          dec_imm = imm_i;
          if (in_instr[14:12] == 3'b000) begin
            case (in_instr)
              32'h00000073: dec_flags[44] = 1'b1;
              32'h00100073: dec_flags[43] = 1'b1;
`ifdef DECODE_CSR_EN
              32'h30200073: dec_flags[45] = 1'b1;
              32'h10200073: dec_flags[46] = 1'b1;
              32'h10500073: dec_flags[47] = 1'b1;
`endif
              default:      dec_ill = 1'b1;
            endcase
          end else begin
`ifdef DECODE_CSR_EN
            // Immediate CSR forms carry the zero-extended rs1 field instead of the CSR address.
            if (in_instr[14]) dec_imm = {27'b0, in_instr[19:15]};
            case (in_instr[14:12])
              3'b001:  dec_flags[41] = 1'b1;
              3'b010:  dec_flags[39] = 1'b1;
              3'b011:  dec_flags[37] = 1'b1;
              3'b101:  dec_flags[42] = 1'b1;
              3'b110:  dec_flags[40] = 1'b1;
              3'b111:  dec_flags[38] = 1'b1;
              default: dec_ill = 1'b1;
            endcase
`else
            dec_ill = 1'b1;
`endif
          end
        end
        default: dec_ill = 1'b1;
      endcase
    end
    if (dec_ill) begin
      dec_flags = '0;
      dec_imm   = '0;
    end
  end

  entry_t          mem [DEPTH];
  entry_t          head_e;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_q] <= '{pc: in_pc, flags: dec_flags, rd: in_instr[11:7], rs1: in_instr[19:15],
                       rs2: in_instr[24:20], imm: dec_imm, illegal: dec_ill};
    end
  end

  // Fields read as zero whenever the queue is empty, so storage needs no reset.
  assign head_e      = mem[head_q];
  assign out_pc      = out_valid ? head_e.pc      : '0;
  assign out_flags   = out_valid ? head_e.flags   : '0;
  assign out_rd      = out_valid ? head_e.rd      : '0;
  assign out_rs1     = out_valid ? head_e.rs1     : '0;
  assign out_rs2     = out_valid ? head_e.rs2     : '0;
  assign out_imm     = out_valid ? head_e.imm     : '0;
  assign out_illegal = out_valid ? head_e.illegal : 1'b0;
  assign count       = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vector table plus FIFO corner-case sequences.
module tb_decode_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [47:0] out_flags;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  count;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_flags(out_flags),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_illegal(out_illegal), .count(count)
  );

  typedef struct {
    logic [31:0] instr;
    int          flag;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        chk_imm;
    logic        ill;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [31:0] instr, input int flag, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                     input logic chk_imm, input logic ill);
    vec_t v;
    v.instr = instr; v.flag = flag; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.chk_imm = chk_imm; v.ill = ill;
    vt.push_back(v);
  endtask

  function automatic logic [47:0] onehot(input int b);
    logic [47:0] r;
    r = '0;
    if (b >= 0) r[b] = 1'b1;
    return r;
  endfunction

  initial begin
    logic [31:0]  pc;
    logic [127:0] got, exp;

    // instr, flag bit (-1 none), rd, rs1, rs2, imm, imm checked, illegal
    add(32'h00500093,  9,  1, 0,  5, 32'h5,        1, 0);
    add(32'hFE000EE3,  0, 29, 0,  0, 32'hFFFFFFFC, 1, 0);
    add(32'h00000012, -1,  0, 0,  0, 32'h0,        1, 1);
    add(32'h00000000, -1,  0, 0,  0, 32'h0,        1, 0);
    add(32'h002081B3, 18,  3, 1,  2, 32'h0,        1, 0);
    add(32'h402081B3, 26,  3, 1,  2, 32'h0,        1, 0);
    add(32'h40335293, 15,  5, 6,  3, 32'h403,      1, 0);
    add(32'h02009093, -1,  1, 1,  0, 32'h0,        1, 1);
    add(32'h123450B7, 28,  1, 8,  3, 32'h12345000, 1, 0);
    add(32'h008000EF,  7,  1, 0,  8, 32'h8,        1, 0);
    add(32'h0020A623, 36, 12, 1,  2, 32'hC,        1, 0);
    add(32'hFFC12283, 33,  5, 2, 28, 32'hFFFFFFFC, 1, 0);
    add(32'h000010E7, -1,  1, 0,  0, 32'h0,        1, 1);
    add(32'h0000000F, -1,  0, 0,  0, 32'h0,        1, 1);
    add(32'h00002063, -1,  0, 0,  0, 32'h0,        1, 1);
    add(32'h00000073, 44,  0, 0,  0, 32'h0,        0, 0);
    add(32'h00100073, 43,  0, 0,  1, 32'h0,        0, 0);
`ifdef DECODE_CSR_EN
    add(32'h30200073, 45,  0, 0,  2, 32'h0,        0, 0);
    add(32'h34129073, 41,  0, 5,  1, 32'h0,        0, 0);
    add(32'h30046073, 40,  0, 8,  0, 32'h8,        1, 0);
`else
    add(32'h30200073, -1,  0, 0,  2, 32'h0,        1, 1);
    add(32'h34129073, -1,  0, 5,  1, 32'h0,        1, 1);
    add(32'h30046073, -1,  0, 8,  0, 32'h0,        1, 1);
`endif

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step(); step();
    rst_n = 1'b1;
    check("reset_ctl", {out_valid, in_ready, count}, {1'b0, 1'b1, 3'd0});
    check("reset_fields", {out_pc, out_flags, out_rd, out_rs1, out_rs2, out_imm, out_illegal}, '0);

    for (int i = 0; i < vt.size(); i++) begin
      pc = 32'h100 + 32'(4 * i);
      in_valid = 1'b1; in_instr = vt[i].instr; in_pc = pc;
      step();
      in_valid = 1'b0;
      check($sformatf("valid_%0d", i), out_valid, 1'b1);
      got = {out_pc, out_flags, out_rd, out_rs1, out_rs2,
             vt[i].chk_imm ? out_imm : 32'h0, out_illegal};
      exp = {pc, onehot(vt[i].flag), vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].ill};
      check($sformatf("vec_%0d_%h", i, vt[i].instr), got, exp);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("drain_%0d", i), count, 3'd0);
    end

    // Fill to full with the consumer stalled.
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1; in_instr = 32'h00000093 | (32'(k) << 20); in_pc = 32'h200 + 32'(4 * k);
      step();
    end
    check("full_ctl", {count, in_ready, out_valid}, {3'(DEPTH), 1'b0, 1'b1});
    in_instr = 32'h06300093; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("full_pop_no_push", count, 3'(DEPTH - 1));
    for (int k = 1; k < DEPTH; k++) begin
      check($sformatf("order_%0d", k), {out_valid, out_pc, out_flags, out_imm},
            {1'b1, 32'h200 + 32'(4 * k), onehot(9), 32'(k)});
      step();
    end
    check("empty_after_drain", {count, out_valid, in_ready}, {3'd0, 1'b0, 1'b1});
    out_ready = 1'b0;

    // Push and pop in the same cycle while non-empty.
    in_valid = 1'b1; in_instr = 32'h00700093; in_pc = 32'h300;
    step();
    in_instr = 32'h00800093; in_pc = 32'h304; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("push_pop_same", {count, out_imm, out_pc}, {3'd1, 32'h8, 32'h304});
    step();
    out_ready = 1'b0;
    check("push_pop_drain", count, 3'd0);

    // Head entry must hold while stalled.
    in_valid = 1'b1; in_instr = 32'h123450B7; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall_%0d", c), {out_valid, out_pc, out_flags, out_rd, out_imm},
            {1'b1, 32'h400, onehot(28), 5'd1, 32'h12345000});
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Flush with three entries buffered and a same-cycle offer.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h500 + 32'(4 * k);
      step();
    end
    check("pre_flush", count, 3'd3);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush", {count, out_valid, in_ready}, {3'd0, 1'b0, 1'b1});
    step();
    check("flush_dropped", {count, out_valid}, {3'd0, 1'b0});

    // Asynchronous reset mid-operation.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h600;
      step();
    end
    in_valid = 1'b0;
    check("pre_reset", count, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {count, out_valid, in_ready, out_imm, out_pc},
          {3'd0, 1'b0, 1'b1, 32'h0, 32'h0});
    step();
    rst_n = 1'b1;
    step();
    check("post_reset", {count, out_valid}, {3'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
